// File: rtl/net_tx_pkt_fifo.sv
// Store-and-forward TX packet FIFO: only whole packets reach the MAC; oversize or non-fitting packets are dropped and counted.
// Latency: m_axis_tvalid rises 2 cycles after the commit edge. Backpressure: s_axis_tready is never deasserted; m_axis stalls hold the output.
module net_tx_pkt_fifo #(
    parameter  int DATA_WIDTH = 512,
    parameter  int DEPTH      = 256,
    parameter  int ADDR_W     = 8,
    parameter  int CNT_W      = 32,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  net_clk,
    input  logic                  net_aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [CNT_W-1:0]      stat_pkt_in,
    output logic [CNT_W-1:0]      stat_pkt_drop,
    output logic [ADDR_W:0]       stat_level
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_PKT  = 2'd1;
    localparam logic [1:0] W_DROP = 2'd2;

    localparam logic [ADDR_W:0] PTR_DEPTH = (ADDR_W+1)'(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] dat;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
    } flit_t;

    flit_t           r_mem [0:DEPTH-1];
    flit_t           r_ram_q;
    flit_t           r_of_dat [0:3];

    logic [1:0]      r_wstate;
    logic            r_s_rdy;
    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_commit_ptr;
    logic [ADDR_W:0] r_fetch_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic [CNT_W-1:0] r_pkt_in;
    logic [CNT_W-1:0] r_pkt_drop;
    logic            r_rd_vld;
    logic [1:0]      r_of_wp;
    logic [1:0]      r_of_rp;
    logic [2:0]      r_of_cnt;

    logic [ADDR_W:0] w_used;
    logic            w_full;
    logic            w_beat;
    logic            w_wr_en;
    logic            w_issue;
    logic            w_pop;
    flit_t           w_in_flit;
    flit_t           w_out_flit;

    // rd_ptr only moves on the output handshake, so flits parked in the output
    // stage still occupy FIFO space; fetch_ptr tracks what has been read from RAM.
    assign w_used    = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_used == PTR_DEPTH);
    assign w_beat    = s_axis_tvalid && r_s_rdy;
    assign w_wr_en   = w_beat && !w_full && (r_wstate != W_DROP);
    assign w_in_flit = '{dat: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast};

    // Up to 3 flits in the output stage plus RAM read in flight keeps 1 flit/cycle.
    assign w_issue = (r_fetch_ptr != r_commit_ptr) &&
                     (({1'b0, r_of_cnt} + {3'b000, r_rd_vld}) < 4'd3);
    assign w_pop   = (r_of_cnt != 3'd0) && m_axis_tready;

    always_ff @(posedge net_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_in_flit;
        end
        if (w_issue) begin
            r_ram_q <= r_mem[r_fetch_ptr[ADDR_W-1:0]];
        end
        if (r_rd_vld) begin
            r_of_dat[r_of_wp] <= r_ram_q;
        end
    end

    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            r_wstate     <= W_IDLE;
            r_s_rdy      <= 1'b0;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_pkt_in     <= '0;
            r_pkt_drop   <= '0;
        end else begin
            r_s_rdy <= 1'b1;
            case (r_wstate)
                W_IDLE, W_PKT: begin
                    if (w_beat) begin
                        if (!w_full) begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            if (s_axis_tlast) begin
                                r_commit_ptr <= r_wr_ptr + 1'b1;
                                r_pkt_in     <= r_pkt_in + 1'b1;
                                r_wstate     <= W_IDLE;
                            end else begin
                                r_wstate <= W_PKT;
                            end
                        end else begin
                            // In W_IDLE wr_ptr already equals commit_ptr, so the rewind is harmless there.
                            r_wr_ptr <= r_commit_ptr;
                            if (s_axis_tlast) begin
                                r_pkt_drop <= r_pkt_drop + 1'b1;
                                r_wstate   <= W_IDLE;
                            end else begin
                                r_wstate <= W_DROP;
                            end
                        end
                    end
                end
                W_DROP: begin
                    if (w_beat && s_axis_tlast) begin
                        r_pkt_drop <= r_pkt_drop + 1'b1;
                        r_wstate   <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            r_fetch_ptr <= '0;
            r_rd_ptr    <= '0;
            r_rd_vld    <= 1'b0;
            r_of_wp     <= '0;
            r_of_rp     <= '0;
            r_of_cnt    <= '0;
        end else begin
            r_rd_vld <= w_issue;
            if (w_issue) begin
                r_fetch_ptr <= r_fetch_ptr + 1'b1;
            end
            if (r_rd_vld) begin
                r_of_wp <= r_of_wp + 1'b1;
            end
            if (w_pop) begin
                r_of_rp  <= r_of_rp + 1'b1;
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({r_rd_vld, w_pop})
                2'b10:   r_of_cnt <= r_of_cnt + 1'b1;
                2'b01:   r_of_cnt <= r_of_cnt - 1'b1;
                default: r_of_cnt <= r_of_cnt;
            endcase
        end
    end

    assign w_out_flit    = r_of_dat[r_of_rp];
    assign m_axis_tdata  = w_out_flit.dat;
    assign m_axis_tkeep  = w_out_flit.keep;
    assign m_axis_tlast  = w_out_flit.last;
    assign m_axis_tvalid = (r_of_cnt != 3'd0);
    assign s_axis_tready = r_s_rdy;
    assign stat_pkt_in   = r_pkt_in;
    assign stat_pkt_drop = r_pkt_drop;
    assign stat_level    = w_used;

endmodule

// File: tb/tb_net_tx_pkt_fifo.sv
// Bench for net_tx_pkt_fifo: scoreboard of committed flits checked against the output stream.
module tb_net_tx_pkt_fifo;

    localparam int DW    = 512;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int CW    = 32;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } flit_t;

    logic          net_clk = 1'b0;
    logic          net_aresetn = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [CW-1:0] stat_pkt_in;
    logic [CW-1:0] stat_pkt_drop;
    logic [AW:0]   stat_level;

    int    total = 0;
    int    bad = 0;
    int    exp_in = 0;
    int    exp_drop = 0;
    bit    rand_rdy = 1'b0;
    flit_t sb[$];

    net_tx_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW)) dut (
        .net_clk       (net_clk),
        .net_aresetn   (net_aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .stat_pkt_in   (stat_pkt_in),
        .stat_pkt_drop (stat_pkt_drop),
        .stat_level    (stat_level)
    );

    always #5 net_clk = ~net_clk;

    initial begin
        forever begin
            @(posedge net_clk);
            #1;
            if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: pops the scoreboard on every handshake and checks AXIS hold rules.
    initial begin
        flit_t cur;
        flit_t prev;
        flit_t exp;
        bit    stall;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge net_clk);
            cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
            if (!net_aresetn) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    total++;
                    if (m_axis_tvalid !== 1'b1 || cur !== prev) begin
                        bad++;
                        $display("FAIL hold_stable vld=%b got=%h exp=%h", m_axis_tvalid, cur, prev);
                    end
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_flit got=%h exp=none", cur);
                    end else begin
                        exp = sb.pop_front();
                        if (cur !== exp) begin
                            bad++;
                            $display("FAIL out_flit got=%h exp=%h", cur, exp);
                        end
                    end
                end
                stall = m_axis_tvalid && !m_axis_tready;
                prev  = cur;
            end
        end
    end

    initial begin
        #1_500_000;
        bad++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge net_clk);
        #1;
    endtask

    task automatic send_pkt(input int len, input bit keep_it, input bit gaps);
        flit_t f;
        logic [KW-1:0] ones;
        ones = '1;
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                step();
            end
            f.d = {16{$urandom}};
            f.l = (i == len - 1);
            f.k = f.l ? (ones >> $urandom_range(0, KW - 1)) : ones;
            if (keep_it) sb.push_back(f);
            s_axis_tdata  = f.d;
            s_axis_tkeep  = f.k;
            s_axis_tlast  = f.l;
            s_axis_tvalid = 1'b1;
            step();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (keep_it) exp_in++;
        else exp_drop++;
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 5000 && sb.size() != 0; c++) step();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_drain got=%0d_left exp=0_left", name, sb.size());
            sb.delete();
        end
        repeat (4) step();
    endtask

    task automatic test_reset();
        net_aresetn = 1'b0;
        #2;
        total++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got=%b%b exp=00", s_axis_tready, m_axis_tvalid);
        end
        total++;
        if (stat_pkt_in !== 0 || stat_pkt_drop !== 0 || stat_level !== 0) begin
            bad++;
            $display("FAIL reset_stats got=%0d/%0d/%0d exp=0/0/0", stat_pkt_in, stat_pkt_drop, stat_level);
        end
        repeat (3) step();
        net_aresetn = 1'b1;
        step();
        total++;
        if (s_axis_tready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b exp=1", s_axis_tready);
        end
    endtask

    task automatic test_single();
        flit_t f;
        bit    seen;
        m_axis_tready = 1'b1;
        f.d = {16{$urandom}};
        f.k = 64'h0000_0000_0000_ffff;
        f.l = 1'b1;
        sb.push_back(f);
        s_axis_tdata  = f.d;
        s_axis_tkeep  = f.k;
        s_axis_tlast  = f.l;
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        exp_in++;
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            if (m_axis_tvalid) seen = 1'b1;
            else step();
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL single_latency got=no_valid exp=valid_within_3");
        end
        wait_drain("single");
        total++;
        if (stat_pkt_in !== CW'(exp_in)) begin
            bad++;
            $display("FAIL single_pkt_in got=%0d exp=%0d", stat_pkt_in, exp_in);
        end
    endtask

    task automatic test_multi();
        flit_t f;
        int    run;
        bit    early;
        logic [KW-1:0] ones;
        ones  = '1;
        early = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f.d = {16{$urandom}};
            f.k = ones;
            f.l = (i == 3);
            sb.push_back(f);
            s_axis_tdata  = f.d;
            s_axis_tkeep  = f.k;
            s_axis_tlast  = f.l;
            s_axis_tvalid = 1'b1;
            step();
            if (m_axis_tvalid) early = 1'b1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        exp_in++;
        total++;
        if (early) begin
            bad++;
            $display("FAIL multi_store_forward got=early_valid exp=no_valid");
        end
        for (int c = 0; c < 4 && !m_axis_tvalid; c++) step();
        run = 0;
        for (int c = 0; c < 4; c++) begin
            if (m_axis_tvalid) run++;
            step();
        end
        total++;
        if (run != 4 || m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL multi_back_to_back got=%0d_then_%b exp=4_then_0", run, m_axis_tvalid);
        end
        wait_drain("multi");
        total++;
        if (stat_pkt_in !== CW'(exp_in)) begin
            bad++;
            $display("FAIL multi_pkt_in got=%0d exp=%0d", stat_pkt_in, exp_in);
        end
    endtask

    task automatic test_exact_fill();
        m_axis_tready = 1'b0;
        send_pkt(DEPTH, 1'b1, 1'b0);
        send_pkt(1, 1'b0, 1'b0);
        step();
        total++;
        if (stat_level !== (AW+1)'(DEPTH) || stat_pkt_drop !== CW'(exp_drop) || stat_pkt_in !== CW'(exp_in)) begin
            bad++;
            $display("FAIL exact_fill got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     stat_level, stat_pkt_in, stat_pkt_drop, DEPTH, exp_in, exp_drop);
        end
        m_axis_tready = 1'b1;
        wait_drain("exact_fill");
    endtask

    task automatic test_overflow();
        m_axis_tready = 1'b0;
        send_pkt(200, 1'b1, 1'b0);
        send_pkt(100, 1'b0, 1'b0);
        step();
        total++;
        if (stat_level !== 9'd200 || stat_pkt_drop !== CW'(exp_drop)) begin
            bad++;
            $display("FAIL overflow_drop got=%0d/%0d exp=200/%0d", stat_level, stat_pkt_drop, exp_drop);
        end
        m_axis_tready = 1'b1;
        wait_drain("overflow");
        repeat (10) step();
        total++;
        if (m_axis_tvalid !== 1'b0 || stat_level !== 0 || stat_pkt_in !== CW'(exp_in)) begin
            bad++;
            $display("FAIL overflow_after got=%b/%0d/%0d exp=0/0/%0d", m_axis_tvalid, stat_level, stat_pkt_in, exp_in);
        end
    endtask

    task automatic test_long();
        m_axis_tready = 1'b1;
        send_pkt(300, 1'b0, 1'b0);
        step();
        total++;
        if (stat_pkt_drop !== CW'(exp_drop) || stat_level !== 0) begin
            bad++;
            $display("FAIL long_drop got=%0d/%0d exp=%0d/0", stat_pkt_drop, stat_level, exp_drop);
        end
        send_pkt(2, 1'b1, 1'b0);
        wait_drain("long");
        total++;
        if (stat_pkt_in !== CW'(exp_in)) begin
            bad++;
            $display("FAIL long_follow got=%0d exp=%0d", stat_pkt_in, exp_in);
        end
    endtask

    task automatic test_random();
        int len;
        rand_rdy = 1'b1;
        for (int p = 0; p < 400; p++) begin
            len = $urandom_range(1, 64);
            for (int c = 0; c < 2000 && (sb.size() + len > 200); c++) step();
            send_pkt(len, 1'b1, 1'b1);
        end
        rand_rdy = 1'b0;
        step();
        m_axis_tready = 1'b1;
        wait_drain("random");
        total++;
        if (stat_pkt_in !== CW'(exp_in) || stat_pkt_drop !== CW'(exp_drop) || stat_level !== 0) begin
            bad++;
            $display("FAIL random_stats got=%0d/%0d/%0d exp=%0d/%0d/0",
                     stat_pkt_in, stat_pkt_drop, stat_level, exp_in, exp_drop);
        end
    endtask

    task automatic test_reset_mid();
        m_axis_tready = 1'b0;
        send_pkt(5, 1'b1, 1'b0);
        repeat (4) step();
        for (int i = 0; i < 2; i++) begin
            s_axis_tdata  = {16{$urandom}};
            s_axis_tkeep  = '1;
            s_axis_tlast  = 1'b0;
            s_axis_tvalid = 1'b1;
            step();
        end
        total++;
        if (m_axis_tvalid !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre_valid got=%b exp=1", m_axis_tvalid);
        end
        net_aresetn   = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        total++;
        if (m_axis_tvalid !== 1'b0 || stat_pkt_in !== 0 || stat_pkt_drop !== 0 || stat_level !== 0) begin
            bad++;
            $display("FAIL mid_reset got=%b/%0d/%0d/%0d exp=0/0/0/0",
                     m_axis_tvalid, stat_pkt_in, stat_pkt_drop, stat_level);
        end
        sb.delete();
        exp_in   = 0;
        exp_drop = 0;
        repeat (2) step();
        net_aresetn = 1'b1;
        step();
        m_axis_tready = 1'b1;
        send_pkt(3, 1'b1, 1'b0);
        wait_drain("mid");
        total++;
        if (stat_pkt_in !== 1 || stat_pkt_drop !== 0) begin
            bad++;
            $display("FAIL mid_after got=%0d/%0d exp=1/0", stat_pkt_in, stat_pkt_drop);
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_single();
        test_multi();
        test_exact_fill();
        test_overflow();
        test_long();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
